// File: rtl/display_pkg.sv
// Shared constants, FSM state type and RAM word packing for the display write scheduler.
package display_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DIN_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  // RAM word layout: {enable, nibble, decimal point}
  function automatic logic [DIN_W-1:0] pack_din(input logic en, input logic [NIB_W-1:0] nib,
                                                input logic dp);
    return {en, nib, dp};
  endfunction

endpackage

// File: rtl/display_write_sched_if.sv
// Requester frames and grants plus the display RAM write port, bundled for the scheduler.
interface display_write_sched_if #(
  parameter int unsigned N_REQ = 2
) ();

  logic [N_REQ-1:0]                  req;
  logic [N_REQ*32-1:0]               frame_data;
  logic [N_REQ*8-1:0]                frame_en;
  logic [N_REQ*8-1:0]                frame_dp;
  logic [N_REQ-1:0]                  ack;
  logic                              busy;
  logic                              done;
  logic                              W;
  logic [display_pkg::ADDR_W-1:0]    WADD;
  logic [display_pkg::DIN_W-1:0]     DIN;

  modport master (
    output req, frame_data, frame_en, frame_dp,
    input  ack, busy, done, W, WADD, DIN
  );

  modport slave (
    input  req, frame_data, frame_en, frame_dp,
    output ack, busy, done, W, WADD, DIN
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last_grant + 1.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(last_grant) + 1 + i) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/display_write_sched.sv
// Round-robin scheduler that latches one requester's 8-digit frame and streams it into the
// display RAM as descending-address writes.
module display_write_sched
  import display_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input logic                  clk,
  input logic                  rst,
  display_write_sched_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                          state_q;
  logic [N_REQ-1:0]                ack_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            w_q;
  logic [ADDR_W-1:0]               wadd_q;
  logic [DIN_W-1:0]                din_q;
  logic [IDX_W-1:0]                last_q;
  logic [ADDR_W-1:0]               cnt_q;
  logic [DIGITS-1:0][NIB_W-1:0]    nib_q;
  logic [DIGITS-1:0]               en_q;
  logic [DIGITS-1:0]               dp_q;

  logic [N_REQ-1:0]                grant;
  logic [IDX_W-1:0]                grant_idx;
  logic [DIGITS*NIB_W-1:0]         sel_data;
  logic [DIGITS-1:0]               sel_en;
  logic [DIGITS-1:0]               sel_dp;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (bus.req),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_en   = '0;
    sel_dp   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_data = bus.frame_data[32*i +: 32];
        sel_en   = bus.frame_en[8*i +: 8];
        sel_dp   = bus.frame_dp[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      w_q     <= 1'b0;
      wadd_q  <= ADDR_W'(DIGITS - 1);
      din_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= ADDR_W'(DIGITS - 1);
      nib_q   <= '0;
      en_q    <= '0;
      dp_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          w_q    <= 1'b0;
          if (|bus.req) begin
            ack_q   <= grant;
            busy_q  <= 1'b1;
            nib_q   <= sel_data;
            en_q    <= sel_en;
            dp_q    <= sel_dp;
            cnt_q   <= ADDR_W'(DIGITS - 1);
            last_q  <= grant_idx;
            state_q <= WRITE;
          end else begin
            ack_q <= '0;
          end
        end
        WRITE: begin
          ack_q  <= '0;
          w_q    <= 1'b1;
          wadd_q <= cnt_q;
          din_q  <= pack_din(en_q[cnt_q], nib_q[cnt_q], dp_q[cnt_q]);
          // Address 0 is the final write; the counter is reloaded on the next grant
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          w_q     <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.W    = w_q;
  assign bus.WADD = wadd_q;
  assign bus.DIN  = din_q;

endmodule

// File: tb/tb_display_write_sched.sv
// Directed bench for display_write_sched: reset, single frame, churn, late request,
// contention, blanking and mid-frame reset.
module tb_display_write_sched;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  display_write_sched_if #(.N_REQ(2)) bus ();

  display_write_sched #(
    .N_REQ (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requester 0: data 7654_3210, en FF, dp 01
  logic [5:0] exp_single [8] = '{6'b101110, 6'b101100, 6'b101010, 6'b101000,
                                 6'b100110, 6'b100100, 6'b100010, 6'b100001};
  // Requester 1: data 89AB_CDEF, en FF, dp 00
  logic [5:0] exp_late   [8] = '{6'b110000, 6'b110010, 6'b110100, 6'b110110,
                                 6'b111000, 6'b111010, 6'b111100, 6'b111110};
  // Requester 0 with en 0F, dp 00
  logic [5:0] exp_blank  [8] = '{6'b001110, 6'b001100, 6'b001010, 6'b001000,
                                 6'b100110, 6'b100100, 6'b100010, 6'b100000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.req        = 2'b00;
    bus.frame_data = {32'h89AB_CDEF, 32'h7654_3210};
    bus.frame_en   = {8'hFF, 8'hFF};
    bus.frame_dp   = {8'h00, 8'h01};
    #1;
    chk("rst_ack", bus.ack, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_w", bus.W, 1'b0);
    chk("rst_wadd", bus.WADD, 3'd7);
    chk("rst_din", bus.DIN, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_ack", bus.ack, 2'b00);
    chk("idle_w", bus.W, 1'b0);

    // Single frame with input churn and a late request from requester 1
    @(negedge clk);
    bus.req = 2'b01;
    tick();
    chk("single_ack", bus.ack, 2'b01);
    chk("single_busy", bus.busy, 1'b1);
    chk("single_w0", bus.W, 1'b0);
    bus.req = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("single_w", bus.W, 1'b1);
      chk("single_wadd", bus.WADD, 32'(7 - i));
      chk("single_din", bus.DIN, exp_single[i]);
      chk("single_noack", bus.ack, 2'b00);
      chk("single_busyw", bus.busy, 1'b1);
      if (i == 1) bus.frame_data[31:0] = 32'hFFFF_FFFF;
      if (i == 2) bus.req = 2'b10;
    end
    tick();
    chk("single_done", bus.done, 1'b1);
    chk("single_wend", bus.W, 1'b0);
    chk("single_busyend", bus.busy, 1'b0);
    chk("single_noack_done", bus.ack, 2'b00);
    tick();
    chk("single_done_clr", bus.done, 1'b0);
    chk("late_ack", bus.ack, 2'b10);
    chk("late_busy", bus.busy, 1'b1);
    bus.req = 2'b00;
    bus.frame_data[31:0] = 32'h7654_3210;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("late_wadd", bus.WADD, 32'(7 - i));
      chk("late_din", bus.DIN, exp_late[i]);
    end
    tick();
    chk("late_done", bus.done, 1'b1);
    tick();
    chk("late_done_clr", bus.done, 1'b0);
    chk("late_idle_ack", bus.ack, 2'b00);

    // Contention: both requesters held high
    @(negedge clk);
    bus.req = 2'b11;
    tick();
    chk("cont_ack0", bus.ack, 2'b01);
    for (int c = 1; c < 30; c++) begin
      tick();
      chk("cont_ack", bus.ack, (c == 10) ? 2'b10 : (c == 20) ? 2'b01 : 2'b00);
      chk("cont_done", bus.done, (c == 9 || c == 19 || c == 29) ? 1'b1 : 1'b0);
      if (c == 20) bus.req = 2'b00;
    end
    tick();
    chk("cont_idle_ack", bus.ack, 2'b00);
    chk("cont_idle_w", bus.W, 1'b0);

    // Blanking upper four digits
    @(negedge clk);
    bus.frame_en[7:0] = 8'h0F;
    bus.frame_dp[7:0] = 8'h00;
    bus.req = 2'b01;
    tick();
    chk("blank_ack", bus.ack, 2'b01);
    bus.req = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("blank_wadd", bus.WADD, 32'(7 - i));
      chk("blank_din", bus.DIN, exp_blank[i]);
    end
    tick();
    chk("blank_done", bus.done, 1'b1);
    tick();

    // Reset in the middle of a frame
    @(negedge clk);
    bus.frame_en[7:0] = 8'hFF;
    bus.req = 2'b01;
    tick();
    chk("mid_ack", bus.ack, 2'b01);
    bus.req = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_w_before", bus.W, 1'b1);
    chk("mid_wadd_before", bus.WADD, 3'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_w_async", bus.W, 1'b0);
    chk("mid_busy_async", bus.busy, 1'b0);
    chk("mid_wadd_async", bus.WADD, 3'd7);
    tick();
    chk("mid_done_rst", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_no_done", bus.done, 1'b0);
      chk("mid_no_w", bus.W, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
